// File: rtl/router_input_rr_arbiter_pkg.sv
// Shared types for the router input round-robin arbiter: buffer state
// encoding and the priority-pointer advance rule.
package router_input_rr_arbiter_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } buf_state_e;

    // Pointer moves to the requester just after the winner, wrapping at n-1.
    function automatic int rr_next(input int idx, input int n);
        if (idx == n - 1) begin
            return 0;
        end else begin
            return idx + 1;
        end
    endfunction

endpackage

// File: rtl/router_input_rr_arbiter_sel.sv
// Combinational rotating-priority selector: first asserted request at or
// after ptr, wrapping around, reported as one-hot, index and any.
module rr_priority_sel #(
    parameter int p_ninputs = 4,
    parameter int p_pw      = $clog2(p_ninputs)
) (
    input  logic [p_ninputs-1:0] req,
    input  logic [p_pw-1:0]      ptr,
    output logic [p_ninputs-1:0] grant,
    output logic [p_pw-1:0]      index,
    output logic                 any
);

    // Scan ptr, ptr+1, ... and latch the first hit; later hits are masked by any.
    always_comb begin
        int  pos_s;
        logic hit_s;
        grant = '0;
        index = '0;
        any   = 1'b0;
        pos_s = 0;
        hit_s = 1'b0;
        for (int k = 0; k < p_ninputs; k++) begin
            if (int'(ptr) + k >= p_ninputs) begin
                pos_s = int'(ptr) + k - p_ninputs;
            end else begin
                pos_s = int'(ptr) + k;
            end
            hit_s        = req[pos_s] & ~any;
            grant[pos_s] = grant[pos_s] | hit_s;
            index        = hit_s ? p_pw'(pos_s) : index;
            any          = any | hit_s;
        end
    end

endmodule

// File: rtl/router_input_rr_arbiter.sv
// Round-robin arbiter feeding a one-entry output register in front of the
// router input port; sustains one packet per cycle.
module router_input_rr_arbiter
    import router_input_rr_arbiter_pkg::*;
#(
    parameter int p_nbits   = 32,
    parameter int p_ninputs = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_val [p_ninputs],
    input  logic [p_nbits-1:0]           in_msg [p_ninputs],
    output logic                         in_rdy [p_ninputs],
    output logic                         out_val,
    output logic [p_nbits-1:0]           out_msg,
    input  logic                         out_rdy,
    output logic [$clog2(p_ninputs)-1:0] grant_id
);

    localparam int PW = $clog2(p_ninputs);

    buf_state_e             state_r;
    buf_state_e             state_next_s;
    logic [PW-1:0]          ptr_r;
    logic [p_ninputs-1:0]   req_s;
    logic [p_ninputs-1:0]   grant_s;
    logic [PW-1:0]          sel_index_s;
    logic                   any_s;
    logic                   can_load_s;
    logic                   load_s;

    // Flatten per-requester valids for the selector.
    always_comb begin
        req_s = '0;
        for (int i = 0; i < p_ninputs; i++) begin
            req_s[i] = in_val[i];
        end
    end

    rr_priority_sel #(
        .p_ninputs (p_ninputs),
        .p_pw      (PW)
    ) u_sel (
        .req   (req_s),
        .ptr   (ptr_r),
        .grant (grant_s),
        .index (sel_index_s),
        .any   (any_s)
    );

    // Slot is free if empty, or if the router drains it this same cycle.
    always_comb begin
        can_load_s = (state_r == ST_EMPTY) | out_rdy;
        load_s     = can_load_s & any_s;
    end

    // Ready goes only to the selected requester, and only when a load can happen.
    always_comb begin
        for (int i = 0; i < p_ninputs; i++) begin
            in_rdy[i] = can_load_s & any_s & grant_s[i];
        end
    end

    // Buffer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Buffer next state: a load always leaves it full, a drain without load empties it.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (any_s) begin
                    state_next_s = ST_FULL;
                end else begin
                    state_next_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_rdy && !any_s) begin
                    state_next_s = ST_EMPTY;
                end else begin
                    state_next_s = ST_FULL;
                end
            end
            default: state_next_s = ST_EMPTY;
        endcase
    end

    // Valid to the router is the buffer occupancy.
    always_comb begin
        out_val = (state_r == ST_FULL);
    end

    // Packet, winner id and priority pointer; all held unless a new packet loads.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_msg  <= '0;
            grant_id <= '0;
            ptr_r    <= '0;
        end else if (load_s) begin
            out_msg  <= in_msg[sel_index_s];
            grant_id <= sel_index_s;
            ptr_r    <= PW'(rr_next(int'(sel_index_s), p_ninputs));
        end else begin
            out_msg  <= out_msg;
            grant_id <= grant_id;
            ptr_r    <= ptr_r;
        end
    end

endmodule

// File: tb/tb_router_input_rr_arbiter.sv
// Self-checking bench for router_input_rr_arbiter: directed scenarios plus
// randomized traffic against a behavioural round-robin model.
module tb_router_input_rr_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_val [N];
    logic [W-1:0] in_msg [N];
    logic         in_rdy [N];
    logic         out_val;
    logic [W-1:0] out_msg;
    logic         out_rdy;
    logic [1:0]   grant_id;

    int errors = 0;
    int checks = 0;

    // behavioural model state
    logic         m_full;
    logic [W-1:0] m_msg;
    int           m_gid;
    int           m_ptr;
    int           m_pick;
    logic         m_can;
    logic         m_rst;
    logic         m_ordy;
    logic [3:0]   exp_rdy;
    logic [W-1:0] msgs [N];

    router_input_rr_arbiter #(.p_nbits(W), .p_ninputs(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_val   (in_val),
        .in_msg   (in_msg),
        .in_rdy   (in_rdy),
        .out_val  (out_val),
        .out_msg  (out_msg),
        .out_rdy  (out_rdy),
        .grant_id (grant_id)
    );

    always #5 clk = ~clk;

    function automatic int model_pick(input logic [3:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [3:0] obs_rdy();
        logic [3:0] r;
        for (int i = 0; i < N; i++) r[i] = in_rdy[i];
        return r;
    endfunction

    // drive inputs, wait for the mid-cycle point, predict in_rdy
    task automatic apply(input logic r, input logic [3:0] v, input logic o);
        reset   = r;
        out_rdy = o;
        for (int i = 0; i < N; i++) begin
            in_val[i] = v[i];
            in_msg[i] = msgs[i];
        end
        m_rst  = r;
        m_ordy = o;
        @(negedge clk);
        m_pick  = model_pick(v, m_ptr);
        m_can   = !m_full || o;
        exp_rdy = (m_can && m_pick >= 0) ? 4'(1 << m_pick) : 4'b0000;
    endtask

    // clock edge, model update, settle
    task automatic advance();
        @(posedge clk);
        if (m_rst) begin
            m_full = 1'b0; m_msg = '0; m_gid = 0; m_ptr = 0;
        end else if (m_can && m_pick >= 0) begin
            m_full = 1'b1; m_msg = msgs[m_pick]; m_gid = m_pick; m_ptr = (m_pick + 1) % N;
        end else if (m_ordy) begin
            m_full = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        apply(1'b1, 4'b0000, 1'b0);
        advance();
        apply(1'b1, 4'b0000, 1'b0);
        advance();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({out_val, out_msg, grant_id, dut.ptr_r, obs_rdy()} !== {1'b0, 32'h0, 2'd0, 2'd0, 4'b0000}) begin
            errors++;
            $display("FAIL reset: val=%0b msg=%h gid=%0d ptr=%0d rdy=%b, want all zero",
                     out_val, out_msg, grant_id, dut.ptr_r, obs_rdy());
        end
    endtask

    task automatic test_single();
        msgs[2] = 32'hA000_0001;
        apply(1'b0, 4'b0100, 1'b1);
        checks++;
        if (obs_rdy() !== 4'b0100) begin
            errors++;
            $display("FAIL single_rdy: got %b want 0100", obs_rdy());
        end
        advance();
        checks++;
        if ({out_val, out_msg, grant_id} !== {1'b1, 32'hA000_0001, 2'd2}) begin
            errors++;
            $display("FAIL single_out: val=%0b msg=%h gid=%0d want 1 a0000001 2", out_val, out_msg, grant_id);
        end
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < N; i++) msgs[i] = $urandom;
            apply(1'b0, 4'b1111, 1'b1);
            checks++;
            if (obs_rdy() !== 4'(1 << order[c]) || obs_rdy() !== exp_rdy) begin
                errors++;
                $display("FAIL rr_rdy[%0d]: got %b want %b", c, obs_rdy(), 4'(1 << order[c]));
            end
            advance();
            checks++;
            if ({out_val, grant_id, out_msg} !== {1'b1, 2'(order[c]), msgs[order[c]]}) begin
                errors++;
                $display("FAIL rr_out[%0d]: val=%0b gid=%0d msg=%h want 1 %0d %h",
                         c, out_val, grant_id, out_msg, order[c], msgs[order[c]]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        msgs[0] = 32'h4000_00FF;
        apply(1'b0, 4'b0001, 1'b1);
        advance();
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < N; i++) msgs[i] = $urandom;
            apply(1'b0, 4'b1111, 1'b0);
            checks++;
            if (obs_rdy() !== 4'b0000) begin
                errors++;
                $display("FAIL bp_rdy[%0d]: got %b want 0000", c, obs_rdy());
            end
            advance();
            checks++;
            if ({out_val, out_msg, grant_id, dut.ptr_r} !== {1'b1, 32'h4000_00FF, 2'd0, 2'd1}) begin
                errors++;
                $display("FAIL bp_hold[%0d]: val=%0b msg=%h gid=%0d ptr=%0d want 1 400000ff 0 1",
                         c, out_val, out_msg, grant_id, dut.ptr_r);
            end
        end
        msgs[1] = $urandom;
        apply(1'b0, 4'b0010, 1'b1);
        checks++;
        if (obs_rdy() !== 4'b0010) begin
            errors++;
            $display("FAIL bp_drain_rdy: got %b want 0010", obs_rdy());
        end
        advance();
        checks++;
        if ({out_val, out_msg, grant_id} !== {1'b1, msgs[1], 2'd1}) begin
            errors++;
            $display("FAIL bp_reload: val=%0b msg=%h gid=%0d want 1 %h 1", out_val, out_msg, grant_id, msgs[1]);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] v   [4] = '{4'b1000, 4'b1000, 4'b0100, 4'b0010};
        int         gid [4] = '{3, 3, 2, 1};
        int         ptr [4] = '{0, 0, 3, 2};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            msgs[gid[c]] = $urandom;
            apply(1'b0, v[c], 1'b1);
            advance();
            checks++;
            if ({out_val, grant_id, dut.ptr_r, out_msg} !== {1'b1, 2'(gid[c]), 2'(ptr[c]), msgs[gid[c]]}) begin
                errors++;
                $display("FAIL wrap[%0d]: val=%0b gid=%0d ptr=%0d msg=%h want 1 %0d %0d %h",
                         c, out_val, grant_id, dut.ptr_r, out_msg, gid[c], ptr[c], msgs[gid[c]]);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        msgs[0] = 32'hDEAD_BEEF;
        apply(1'b0, 4'b0001, 1'b1);
        advance();
        msgs[1] = 32'h1234_5678;
        apply(1'b1, 4'b0010, 1'b0);
        advance();
        checks++;
        if ({out_val, out_msg, dut.ptr_r} !== {1'b0, 32'h0, 2'd0}) begin
            errors++;
            $display("FAIL mid_reset: val=%0b msg=%h ptr=%0d want 0 0 0", out_val, out_msg, dut.ptr_r);
        end
        for (int c = 0; c < 3; c++) begin
            apply(1'b0, 4'b0000, 1'b1);
            advance();
            checks++;
            if (out_val !== 1'b0 || out_msg === 32'hDEAD_BEEF) begin
                errors++;
                $display("FAIL mid_reset_drop[%0d]: val=%0b msg=%h want 0 and not deadbeef", c, out_val, out_msg);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] v;
        logic       o;
        logic       r;
        for (int c = 0; c < 400; c++) begin
            v = 4'($urandom);
            o = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 63) == 0);
            for (int i = 0; i < N; i++) msgs[i] = $urandom;
            apply(r, v, o);
            checks++;
            if (obs_rdy() !== exp_rdy) begin
                errors++;
                $display("FAIL rand_rdy[%0d]: got %b want %b", c, obs_rdy(), exp_rdy);
            end
            advance();
            checks++;
            if ({out_val, out_msg, grant_id, dut.ptr_r} !== {m_full, m_msg, 2'(m_gid), 2'(m_ptr)}) begin
                errors++;
                $display("FAIL rand_state[%0d]: val=%0b msg=%h gid=%0d ptr=%0d want %0b %h %0d %0d",
                         c, out_val, out_msg, grant_id, dut.ptr_r, m_full, m_msg, m_gid, m_ptr);
            end
        end
    endtask

    initial begin
        m_full = 1'b0; m_msg = '0; m_gid = 0; m_ptr = 0;
        for (int i = 0; i < N; i++) msgs[i] = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
